// File: rtl/control_unit_fsm.sv
// Multi-cycle RV32I control unit: sequences each instruction through FETCH/DECODE/EXE(/MEM/WB)
// and decodes datapath controls from the state and the instruction word. Option: MEM_WAIT_EN.
module control_unit_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        PCEn,
  output logic        regFileWe,
  output logic [3:0]  aluControl,
  output logic        aluSrcMuxSel,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic [1:0]  memSize,
  output logic        memUnsigned,
  output logic        busWe,
  output logic        busReq,
  output logic        illegalInstr
);

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned RFWD_W  = 3;
  localparam int unsigned MSIZE_W = 2;

  localparam logic [OPC_W-1:0] OP_R  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_L  = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_I  = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_S  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_B  = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LU = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AU = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_J  = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JL = 7'b1100111;

  localparam logic [RFWD_W-1:0] RFWD_ALU  = 3'd0;
  localparam logic [RFWD_W-1:0] RFWD_MEM  = 3'd1;
  localparam logic [RFWD_W-1:0] RFWD_IMM  = 3'd2;
  localparam logic [RFWD_W-1:0] RFWD_AUPC = 3'd3;
  localparam logic [RFWD_W-1:0] RFWD_PC4  = 3'd4;

  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    R_EXE,
    I_EXE,
    B_EXE,
    LU_EXE,
    AU_EXE,
    J_EXE,
    JL_EXE,
    S_EXE,
    S_MEM,
    L_EXE,
    L_MEM,
    L_WB
  } state_e;

  state_e state_q;
  state_e state_d;
  state_e exe_state_c;
  logic   opcode_legal_c;

  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;
  logic             funct7_b5;
  logic             unused_instr_bits;

  assign opcode    = instrCode[6:0];
  assign funct3    = instrCode[14:12];
  assign funct7_b5 = instrCode[30];

  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // Memory-phase handshake: with wait states the access holds until the bus completes.
  logic mem_done_c;
`ifdef MEM_WAIT_EN
  assign mem_done_c = busReady;
`else
  logic unused_bus_ready;
  assign unused_bus_ready = busReady;
  assign mem_done_c       = 1'b1;
`endif

  // Opcode to execute-state mapping.
  always_comb begin : decode_opcode
    opcode_legal_c = 1'b1;
    exe_state_c    = FETCH;
    case (opcode)
      OP_R:    exe_state_c = R_EXE;
      OP_L:    exe_state_c = L_EXE;
      OP_I:    exe_state_c = I_EXE;
      OP_S:    exe_state_c = S_EXE;
      OP_B:    exe_state_c = B_EXE;
      OP_LU:   exe_state_c = LU_EXE;
      OP_AU:   exe_state_c = AU_EXE;
      OP_J:    exe_state_c = J_EXE;
      OP_JL:   exe_state_c = JL_EXE;
      default: opcode_legal_c = 1'b0;
    endcase
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = exe_state_c;
      S_EXE:   state_d = S_MEM;
      S_MEM:   state_d = mem_done_c ? FETCH : S_MEM;
      L_EXE:   state_d = L_MEM;
      L_MEM:   state_d = mem_done_c ? L_WB : L_MEM;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode straight from state and instruction so the datapath sees them in-cycle.
  always_comb begin : drive_outputs
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluControl    = ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    memSize       = MSIZE_W'(0);
    memUnsigned   = 1'b0;
    busWe         = 1'b0;
    busReq        = 1'b0;
    illegalInstr  = 1'b0;
    case (state_q)
      FETCH: PCEn = 1'b1;
      DECODE: illegalInstr = ~opcode_legal_c;
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = {funct7_b5, funct3};
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // Only shift-right immediates use funct7[5] (SRLI vs SRAI); elsewhere it is immediate data.
        aluControl   = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = {1'b0, funct3};
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_IMM;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_AUPC;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        jal           = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        jalr          = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        memSize      = funct3[1:0];
        memUnsigned  = funct3[2];
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        memSize      = funct3[1:0];
        memUnsigned  = funct3[2];
        busReq       = 1'b1;
        busWe        = 1'b1;
      end
      L_EXE: begin
        aluSrcMuxSel = 1'b1;
        memSize      = funct3[1:0];
        memUnsigned  = funct3[2];
      end
      L_MEM: begin
        aluSrcMuxSel = 1'b1;
        memSize      = funct3[1:0];
        memUnsigned  = funct3[2];
        busReq       = 1'b1;
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_MEM;
        memSize       = funct3[1:0];
        memUnsigned   = funct3[2];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: walks each instruction class cycle by cycle and checks
// every output against hand-computed values; follows MEM_WAIT_EN when defined.
module tb_control_unit_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] instrCode;
  logic        busReady;
  logic        PCEn;
  logic        regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic [1:0]  memSize;
  logic        memUnsigned;
  logic        busWe;
  logic        busReq;
  logic        illegalInstr;

  int n_checks = 0;
  int n_pass   = 0;

  control_unit_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .instrCode    (instrCode),
    .busReady     (busReady),
    .PCEn         (PCEn),
    .regFileWe    (regFileWe),
    .aluControl   (aluControl),
    .aluSrcMuxSel (aluSrcMuxSel),
    .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .branch       (branch),
    .jal          (jal),
    .jalr         (jalr),
    .memSize      (memSize),
    .memUnsigned  (memUnsigned),
    .busWe        (busWe),
    .busReq       (busReq),
    .illegalInstr (illegalInstr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic expect_out(input string tag, input logic pcen, input logic we,
                            input logic [3:0] alu, input logic src, input logic [2:0] rfwd,
                            input logic br, input logic jl, input logic jr,
                            input logic [1:0] msz, input logic mu, input logic bwe,
                            input logic breq, input logic ill);
    check($sformatf("%s.PCEn", tag),          32'(PCEn),          32'(pcen));
    check($sformatf("%s.regFileWe", tag),     32'(regFileWe),     32'(we));
    check($sformatf("%s.aluControl", tag),    32'(aluControl),    32'(alu));
    check($sformatf("%s.aluSrcMuxSel", tag),  32'(aluSrcMuxSel),  32'(src));
    check($sformatf("%s.RFWDSrcMuxSel", tag), 32'(RFWDSrcMuxSel), 32'(rfwd));
    check($sformatf("%s.branch", tag),        32'(branch),        32'(br));
    check($sformatf("%s.jal", tag),           32'(jal),           32'(jl));
    check($sformatf("%s.jalr", tag),          32'(jalr),          32'(jr));
    check($sformatf("%s.memSize", tag),       32'(memSize),       32'(msz));
    check($sformatf("%s.memUnsigned", tag),   32'(memUnsigned),   32'(mu));
    check($sformatf("%s.busWe", tag),         32'(busWe),         32'(bwe));
    check($sformatf("%s.busReq", tag),        32'(busReq),        32'(breq));
    check($sformatf("%s.illegalInstr", tag),  32'(illegalInstr),  32'(ill));
  endtask

  task automatic exp_fetch(input string tag);
    expect_out(tag, 1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_decode(input string tag);
    expect_out(tag, 1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents an instruction in FETCH and steps through a legal DECODE.
  task automatic start_instr(input string tag, input logic [31:0] instr);
    instrCode = instr;
    exp_fetch($sformatf("%s.fetch", tag));
    next_cycle();
    exp_decode($sformatf("%s.decode", tag));
    next_cycle();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset     = 1'b0;
    busReady  = 1'b1;
    instrCode = 32'h0000_0013;
    repeat (2) @(negedge clk);
    exp_fetch("reset_hold");
    reset = 1'b1;

    // add x3,x1,x2
    start_instr("add", 32'h002081B3);
    expect_out("add.r_exe", 0, 1, 4'h0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();

    // sub, srai, addi with bit30 of the immediate set
    start_instr("sub", 32'h40208233);
    expect_out("sub.r_exe", 0, 1, 4'h8, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();
    start_instr("srai", 32'h4020D213);
    expect_out("srai.i_exe", 0, 1, 4'hD, 1, 3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();
    start_instr("addi_neg", 32'hC0000093);
    expect_out("addi_neg.i_exe", 0, 1, 4'h0, 1, 3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();

    // lbu: five-cycle load
    start_instr("lbu", 32'h0040C183);
    expect_out("lbu.l_exe", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    next_cycle();
    expect_out("lbu.l_mem", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd0, 1, 0, 1, 0);
    next_cycle();
    expect_out("lbu.l_wb", 0, 1, 4'h0, 1, 3'd1, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    next_cycle();

    // sw with the bus stalled for three cycles
    busReady = 1'b0;
    start_instr("sw", 32'h0020A223);
    expect_out("sw.s_exe", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd2, 0, 0, 0, 0);
    next_cycle();
`ifdef MEM_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("sw.s_mem_wait%0d", i), 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd2, 0, 1, 1, 0);
      next_cycle();
    end
    busReady = 1'b1;
    expect_out("sw.s_mem_done", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd2, 0, 1, 1, 0);
    next_cycle();
`else
    expect_out("sw.s_mem", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd2, 0, 1, 1, 0);
    next_cycle();
`endif
    exp_fetch("sw.after");
    busReady = 1'b1;

    // branches and jumps
    start_instr("beq", 32'h00208463);
    expect_out("beq.b_exe", 0, 0, 4'h0, 0, 3'd0, 1, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();
    start_instr("bne", 32'h00209463);
    expect_out("bne.b_exe", 0, 0, 4'h1, 0, 3'd0, 1, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();
    start_instr("jal", 32'h000000EF);
    expect_out("jal.j_exe", 0, 1, 4'h0, 0, 3'd4, 0, 1, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();
    start_instr("jalr", 32'h000080E7);
    expect_out("jalr.jl_exe", 0, 1, 4'h0, 1, 3'd4, 0, 0, 1, 2'd0, 0, 0, 0, 0);
    next_cycle();
    start_instr("lui", 32'h123450B7);
    expect_out("lui.lu_exe", 0, 1, 4'h0, 0, 3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();
    start_instr("auipc", 32'h00000097);
    expect_out("auipc.au_exe", 0, 1, 4'h0, 0, 3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    next_cycle();

    // illegal opcode: one DECODE pulse, then straight back to FETCH
    instrCode = 32'h0000007F;
    exp_fetch("ill.fetch");
    next_cycle();
    expect_out("ill.decode", 0, 0, 4'h0, 0, 3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 1);
    next_cycle();
    exp_fetch("ill.after");

    // reset asserted during L_MEM abandons the load
    start_instr("lbu_rst", 32'h0040C183);
    expect_out("lbu_rst.l_exe", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd0, 1, 0, 0, 0);
    next_cycle();
    expect_out("lbu_rst.l_mem", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd0, 1, 0, 1, 0);
    reset = 1'b0;
    #1;
    exp_fetch("rst_mid.async");
    next_cycle();
    exp_fetch("rst_mid.held");
    reset = 1'b1;
    exp_fetch("rst_mid.release");
    next_cycle();
    exp_decode("rst_mid.decode");
    next_cycle();
    expect_out("rst_mid.l_exe", 0, 0, 4'h0, 1, 3'd0, 0, 0, 0, 2'd0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports listed as: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these ports: instrCode  in  32  current instruction word from instruction memory.
REQ-003 The block SHALL have these ports: busReady  in  1  data-bus access complete (used only with MEM_WAIT_EN).
REQ-004 The block SHALL have these ports: PCEn  out  1; regFileWe  out  1; aluControl  out  4; aluSrcMuxSel  out  1; RFWDSrcMuxSel  out  3; branch  out  1; jal  out  1; jalr  out  1.
REQ-005 The block SHALL have these ports: memSize  out  2; memUnsigned  out  1; busWe  out  1 (store strobe); busReq  out  1 (bus access request); illegalInstr  out  1 (one-cycle pulse).

Function
REQ-006 The block SHALL decode opcodes R=0110011, L=0000011, I=0010011, S=0100011, B=1100011, LU=0110111, AU=0010111, J=1101111, JL=1100111; all other opcodes SHALL be illegal.
REQ-007 The block SHALL use these states: FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB.
REQ-008 Transitions SHALL be: FETCH->DECODE; DECODE->opcode's EXE state (illegal opcode->FETCH); S_EXE->S_MEM; L_EXE->L_MEM; L_MEM->L_WB; S_MEM, L_WB and every other EXE state->FETCH.
REQ-009 PCEn SHALL be 1 only in FETCH.
REQ-010 regFileWe SHALL be 1 only in R_EXE, I_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE and L_WB.
REQ-011 aluControl SHALL be {funct7[5],funct3} in R_EXE; {funct7[5],funct3} in I_EXE when funct3=101, else {0,funct3}; {0,funct3} in B_EXE; 4'b0000 (ADD) in all other states.
REQ-012 aluSrcMuxSel SHALL be 1 in I_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB and JL_EXE, and 0 otherwise.
REQ-013 RFWDSrcMuxSel SHALL be 0 in R/I_EXE, 1 in L_WB, 2 in LU_EXE, 3 in AU_EXE and 4 in J/JL_EXE; it SHALL be 0 in all other states.
REQ-014 In B_EXE, branch SHALL be 1. In J_EXE, jal SHALL be 1. In JL_EXE, jalr SHALL be 1. All three SHALL be 0 in every other state.
REQ-015 memSize SHALL equal funct3[1:0] and memUnsigned SHALL equal funct3[2] in S_EXE, S_MEM, L_EXE, L_MEM and L_WB; both SHALL be 0 in all other states.
REQ-016 busReq SHALL be 1 in S_MEM and L_MEM; busWe SHALL be 1 only in S_MEM.
REQ-017 illegalInstr SHALL be 1 for exactly the single DECODE cycle holding an illegal opcode, and that instruction SHALL produce no regFileWe or busWe.
REQ-018 All outputs SHALL be combinational functions of the state register and instrCode, with no output registering.
REQ-019 Instruction latency SHALL be 3 cycles for R/I/B/LU/AU/J/JL, 4 for S, 5 for L and 2 for illegal, when no wait states occur.

Reset
REQ-020 While reset=0, the state SHALL be FETCH, asynchronously.
REQ-021 Assertion of reset mid-instruction SHALL abandon the instruction, and no regFileWe or busWe SHALL be issued after the reset is asserted.
REQ-022 The first rising edge after reset deasserts SHALL be taken in FETCH with PCEn=1, and all other outputs SHALL be at their FETCH values (all 0).

Configuration
REQ-023 With macro MEM_WAIT_EN defined, S_MEM and L_MEM SHALL hold while busReady=0 and SHALL advance on the edge where busReady=1, with busReq and busWe held stable throughout.
REQ-024 With MEM_WAIT_EN undefined, busReady SHALL be ignored and S_MEM and L_MEM SHALL last exactly one cycle.

Verification
REQ-025 Scenario (ADD): reset pulse, then instrCode=0x002081B3 (add x3,x1,x2) -> states FETCH,DECODE,R_EXE; regFileWe=1 and aluControl=0000 in cycle 3 only; PCEn=1 in cycle 1.
REQ-026 Scenario (SUB/SRAI): instrCode=0x40208233 (sub) -> R_EXE aluControl=1000; instrCode=0x4020D213 (srai) -> I_EXE aluControl=1101, aluSrcMuxSel=1.
REQ-027 Scenario (LBU): instrCode=0x0040C183 (lbu) -> 5-cycle sequence; memSize=00 and memUnsigned=1 in L_EXE through L_WB; busReq=1 in L_MEM; regFileWe=1 and RFWDSrcMuxSel=1 in L_WB.
REQ-028 Scenario (SW with wait states, MEM_WAIT_EN): instrCode=0x0020A223 (sw) with busReady=0 for 3 cycles -> S_MEM lasts 4 cycles with busWe=1 throughout; without MEM_WAIT_EN, S_MEM lasts 1 cycle.
REQ-029 Scenario (branch/jump/illegal): instrCode=0x00208463 (beq) -> branch=1 and aluControl=0000 in B_EXE; instrCode=0x000000EF (jal) -> jal=1, RFWDSrcMuxSel=4; instrCode=0x0000007F (illegal) -> illegalInstr pulses once and the next state is FETCH.
REQ-030 Scenario (reset mid-operation): reset asserted during L_MEM -> state is FETCH immediately, and no L_WB write occurs.
